// File: rtl/alu_wb_stage.sv
// Purpose: ALU writeback stage: carry/zero/parity flags, 2-entry in-order regfile write buffer, branch pulse.
// Latency: flags, writes and br_take are visible one cycle after accept; a write leaves at the next wr_ready edge.
// Backpressure: in_ready drops while both buffer entries are full; it depends only on registered occupancy.
module alu_wb_stage #(
  parameter int DW  = 8,
  parameter int RAW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     alu_cmd,
  input  logic [RAW-1:0] in_dest,
  input  logic [DW-1:0]  in_rslt,
  input  logic           in_sc,
  input  logic           in_absj,
  output logic           sc_i,
  output logic           flag_z,
  output logic           flag_p,
  output logic           wr_en,
  output logic [RAW-1:0] wr_addr,
  output logic [DW-1:0]  wr_data,
  input  logic           wr_ready,
  output logic           br_take,
  output logic [1:0]     occ
);

  typedef struct packed {
    logic [RAW-1:0] addr;
    logic [DW-1:0]  data;
  } wb_entry_t;

  localparam logic [2:0] CMD_CMP = 3'b010;
  localparam logic [2:0] CMD_XOR = 3'b011;
  localparam logic [2:0] CMD_ROT = 3'b100;
  localparam logic [2:0] CMD_AND = 3'b101;
  localparam logic [2:0] CMD_ADD = 3'b111;

  // entry 0 is always the head; entry 1 shifts down on pop
  wb_entry_t ent0_q;
  wb_entry_t ent1_q;
  wb_entry_t new_ent;

  logic accept;
  logic is_write;
  logic is_add;
  logic is_cmp;
  logic push;
  logic pop;
  logic [1:0] occ_after_pop;

  // occupancy is at most 2, so bit 1 alone marks the buffer full
  assign in_ready = ~occ[1];
  assign wr_en    = (occ != 2'd0);
  assign wr_addr  = ent0_q.addr;
  assign wr_data  = ent0_q.data;

  assign accept   = in_valid & in_ready;
  assign is_add   = (alu_cmd == CMD_ADD);
  assign is_cmp   = (alu_cmd == CMD_CMP);
  assign is_write = is_add | (alu_cmd == CMD_XOR) | (alu_cmd == CMD_ROT) | (alu_cmd == CMD_AND);
  assign push     = accept & is_write;
  assign pop      = wr_en & wr_ready;

  assign new_ent.addr = in_dest;
  assign new_ent.data = in_rslt;

  // slot that a push lands in, after any same-cycle pop has shifted the queue
  assign occ_after_pop = occ - {1'b0, pop};

  // write buffer: shift on pop, append at the first free slot on push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ    <= 2'd0;
    end else begin
      if (pop) begin
        ent0_q <= ent1_q;
      end
      if (push) begin
        if (occ_after_pop == 2'd0) begin
          ent0_q <= new_ent;
        end else begin
          ent1_q <= new_ent;
        end
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // architectural flags: z/p on any writing command, carry only on add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_i   <= 1'b0;
      flag_z <= 1'b0;
      flag_p <= 1'b0;
    end else if (push) begin
      flag_z <= (in_rslt == '0);
      flag_p <= ^in_rslt;
      if (is_add) begin
        sc_i <= in_sc;
      end
    end
  end

  // branch pulse: one cycle per accepted compare whose outcome is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_take <= 1'b0;
    end else begin
      br_take <= accept & is_cmp & in_absj;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Purpose: directed self-checking bench for alu_wb_stage.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Backpressure: wr_ready is driven directly by the directed steps.
module tb_alu_wb_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] alu_cmd;
  logic [2:0] in_dest;
  logic [7:0] in_rslt;
  logic       in_sc;
  logic       in_absj;
  logic       sc_i;
  logic       flag_z;
  logic       flag_p;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       br_take;
  logic [1:0] occ;

  int n_checks = 0;
  int n_errors = 0;

  alu_wb_stage #(.DW(8), .RAW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_cmd  (alu_cmd),
    .in_dest  (in_dest),
    .in_rslt  (in_rslt),
    .in_sc    (in_sc),
    .in_absj  (in_absj),
    .sc_i     (sc_i),
    .flag_z   (flag_z),
    .flag_p   (flag_p),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .br_take  (br_take),
    .occ      (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] cmd, input logic [2:0] dest,
                       input logic [7:0] rslt, input logic sc, input logic absj);
    in_valid = v;
    alu_cmd  = cmd;
    in_dest  = dest;
    in_rslt  = rslt;
    in_sc    = sc;
    in_absj  = absj;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"}, in_ready, 1);
    chk({tag, ".sc_i"},     sc_i,     0);
    chk({tag, ".flag_z"},   flag_z,   0);
    chk({tag, ".flag_p"},   flag_p,   0);
    chk({tag, ".wr_en"},    wr_en,    0);
    chk({tag, ".wr_addr"},  wr_addr,  0);
    chk({tag, ".wr_data"},  wr_data,  0);
    chk({tag, ".br_take"},  br_take,  0);
    chk({tag, ".occ"},      occ,      0);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_ready = 1'b0;
    drive(1'b0, 3'b000, 3'd0, 8'h00, 1'b0, 1'b0);
    #12;
    chk_reset_vals("reset");
    #1;
    rst_n = 1'b1;
    tick();

    // add F0+20 = 10 carry 1 -> dest 3
    wr_ready = 1'b1;
    drive(1'b1, 3'b111, 3'd3, 8'h10, 1'b1, 1'b0);
    tick();
    chk("add1.sc_i",    sc_i,    1);
    chk("add1.flag_z",  flag_z,  0);
    chk("add1.flag_p",  flag_p,  1);
    chk("add1.wr_en",   wr_en,   1);
    chk("add1.wr_addr", wr_addr, 3);
    chk("add1.wr_data", wr_data, 8'h10);
    chk("add1.occ",     occ,     1);

    // back-to-back add with carry 0, result 0: push+pop keeps occ at 1
    drive(1'b1, 3'b111, 3'd4, 8'h00, 1'b0, 1'b0);
    tick();
    chk("add2.sc_i",    sc_i,    0);
    chk("add2.flag_z",  flag_z,  1);
    chk("add2.flag_p",  flag_p,  0);
    chk("add2.occ",     occ,     1);
    chk("add2.wr_addr", wr_addr, 4);
    chk("add2.in_ready", in_ready, 1);
    drive(1'b0, 3'b000, 3'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("drain1.occ",   occ,   0);
    chk("drain1.wr_en", wr_en, 0);

    // fill buffer with writes held off
    wr_ready = 1'b0;
    drive(1'b1, 3'b011, 3'd1, 8'h00, 1'b0, 1'b0);
    tick();
    chk("xor.occ",    occ,    1);
    chk("xor.flag_z", flag_z, 1);
    drive(1'b1, 3'b101, 3'd2, 8'h0F, 1'b0, 1'b0);
    tick();
    chk("and.occ",      occ,      2);
    chk("and.in_ready", in_ready, 0);
    chk("and.flag_z",   flag_z,   0);
    chk("and.flag_p",   flag_p,   0);
    chk("and.wr_addr",  wr_addr,  1);
    chk("and.wr_data",  wr_data,  8'h00);

    // third result offered while full: must be ignored, head held
    drive(1'b1, 3'b111, 3'd7, 8'hFE, 1'b1, 1'b0);
    tick();
    chk("full.occ",     occ,     2);
    chk("full.sc_i",    sc_i,    0);
    chk("full.flag_p",  flag_p,  0);
    chk("full.wr_addr", wr_addr, 1);
    chk("full.wr_data", wr_data, 8'h00);

    // release writes with in_valid still high: pop only, no accept
    wr_ready = 1'b1;
    tick();
    chk("pop1.occ",      occ,      1);
    chk("pop1.in_ready", in_ready, 1);
    chk("pop1.wr_addr",  wr_addr,  2);
    chk("pop1.wr_data",  wr_data,  8'h0F);
    chk("pop1.sc_i",     sc_i,     0);
    drive(1'b0, 3'b000, 3'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("pop2.occ",   occ,   0);
    chk("pop2.wr_en", wr_en, 0);

    // compares: taken then not taken, then a lone taken one
    drive(1'b1, 3'b010, 3'd5, 8'h01, 1'b0, 1'b1);
    tick();
    chk("cmp1.br_take", br_take, 1);
    chk("cmp1.wr_en",   wr_en,   0);
    chk("cmp1.flag_p",  flag_p,  0);
    chk("cmp1.flag_z",  flag_z,  0);
    drive(1'b1, 3'b010, 3'd5, 8'h00, 1'b0, 1'b0);
    tick();
    chk("cmp2.br_take", br_take, 0);
    chk("cmp2.occ",     occ,     0);
    drive(1'b1, 3'b010, 3'd5, 8'h00, 1'b0, 1'b1);
    tick();
    chk("cmp3.br_take", br_take, 1);
    drive(1'b0, 3'b000, 3'd0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("cmp3.pulse_end", br_take, 0);

    // no-op command with zero result changes nothing
    drive(1'b1, 3'b110, 3'd6, 8'h00, 1'b1, 1'b1);
    tick();
    chk("nop.flag_z",  flag_z,  0);
    chk("nop.sc_i",    sc_i,    0);
    chk("nop.wr_en",   wr_en,   0);
    chk("nop.occ",     occ,     0);
    chk("nop.br_take", br_take, 0);

    // fill buffer with flags set, then reset mid-cycle
    wr_ready = 1'b0;
    drive(1'b1, 3'b111, 3'd5, 8'h01, 1'b1, 1'b0);
    tick();
    chk("pre_rst.sc_i", sc_i, 1);
    drive(1'b1, 3'b101, 3'd6, 8'h07, 1'b0, 1'b0);
    tick();
    chk("pre_rst.occ",    occ,    2);
    chk("pre_rst.flag_p", flag_p, 1);
    drive(1'b0, 3'b000, 3'd0, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    #3;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    tick();
    chk("post_rst.wr_en", wr_en, 0);
    chk("post_rst.occ",   occ,   0);
    tick();
    chk("post_rst2.wr_en", wr_en, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    n_errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
